// File: rtl/brcomp_pkg.sv
// Shared types and decode helpers for the iterative branch comparator.
package brcomp_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } brc_state_e;

    function automatic logic is_unsigned(input logic [2:0] op);
        return op[1];
    endfunction

    function automatic logic is_illegal(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

    function automatic logic br_taken(input logic [2:0] op, input logic less, input logic equal);
        logic t;
        t = 1'b0;
        case (br_op_e'(op))
            BEQ:         t = equal;
            BNE:         t = ~equal;
            BLT, BLTU:   t = less;
            BGE, BGEU:   t = ~less;
            default:     t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/brcomp_slice.sv
// One SLICE-wide magnitude/equality compare; combinational.
// sign_fix flips both MSBs so a two's-complement top slice orders correctly.
module brcomp_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             sign_fix,
    output logic             lt,
    output logic             eq
);
    localparam logic [SLICE-1:0] MSB_MASK = {1'b1, {(SLICE-1){1'b0}}};

    logic [SLICE-1:0] a_x;
    logic [SLICE-1:0] b_x;

    assign a_x = a ^ ({SLICE{sign_fix}} & MSB_MASK);
    assign b_x = b ^ ({SLICE{sign_fix}} & MSB_MASK);
    assign lt  = a_x < b_x;
    assign eq  = a == b;

endmodule

// File: rtl/brcomp_iter.sv
// Multi-cycle branch comparator, MSB slice first; N=WIDTH/SLICE cycles (BRCOMP_EARLY_EXIT_EN: stop at first differing slice).
// Accepts only in IDLE; result holds in DONE until i_ready; i_flush aborts from any state.
module brcomp_iter
    import brcomp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic [2:0]       i_br_op,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_less,
    output logic             o_br_equal,
    output logic             o_br_taken,
    output logic             o_illegal
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("brcomp_iter: WIDTH must be a multiple of SLICE");
    end

    brc_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic             decided_q, less_q;
    logic [WIDTH-1:0] rs1_q, rs2_q;
    logic [2:0]       op_q;
    logic             valid_q, br_less_q, br_equal_q, br_taken_q, illegal_q;

    logic [SLICE-1:0] a_sl, b_sl;
    logic             sign_fix, slice_lt, slice_eq;
    logic             decided_d, less_d, finish;

    assign a_sl     = rs1_q[cnt_q*SLICE +: SLICE];
    assign b_sl     = rs2_q[cnt_q*SLICE +: SLICE];
    assign sign_fix = (cnt_q == CNT_TOP) && !is_unsigned(op_q);

    brcomp_slice #(.SLICE(SLICE)) u_slice (
        .a        (a_sl),
        .b        (b_sl),
        .sign_fix (sign_fix),
        .lt       (slice_lt),
        .eq       (slice_eq)
    );

    // Only the first (most significant) differing slice decides the ordering.
    assign decided_d = decided_q | ~slice_eq;
    assign less_d    = decided_q ? less_q : (~slice_eq & slice_lt);
`ifdef BRCOMP_EARLY_EXIT_EN
    assign finish    = (cnt_q == '0) || !slice_eq;
`else
    assign finish    = (cnt_q == '0);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            decided_q  <= 1'b0;
            less_q     <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            op_q       <= 3'b000;
            valid_q    <= 1'b0;
            br_less_q  <= 1'b0;
            br_equal_q <= 1'b0;
            br_taken_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (i_flush) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            decided_q  <= 1'b0;
            less_q     <= 1'b0;
            valid_q    <= 1'b0;
            br_less_q  <= 1'b0;
            br_equal_q <= 1'b0;
            br_taken_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        rs1_q     <= i_rs1_data;
                        rs2_q     <= i_rs2_data;
                        op_q      <= i_br_op;
                        cnt_q     <= CNT_TOP;
                        decided_q <= 1'b0;
                        less_q    <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    decided_q <= decided_d;
                    less_q    <= less_d;
                    if (finish) begin
                        state_q    <= DONE;
                        valid_q    <= 1'b1;
                        br_less_q  <= less_d;
                        br_equal_q <= ~decided_d;
                        br_taken_q <= br_taken(op_q, less_d, ~decided_d);
                        illegal_q  <= is_illegal(op_q);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_q    <= IDLE;
                        valid_q    <= 1'b0;
                        br_less_q  <= 1'b0;
                        br_equal_q <= 1'b0;
                        br_taken_q <= 1'b0;
                        illegal_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_valid    = valid_q;
    assign o_br_less  = br_less_q;
    assign o_br_equal = br_equal_q;
    assign o_br_taken = br_taken_q;
    assign o_illegal  = illegal_q;

endmodule
